// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan display:
// segment type, blank pattern, hex-to-segment table and scan-state enum.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low segments, bit 6 = a ... bit 0 = g; entry n is the glyph for hex n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // D
    7'b0110001,  // C
    7'b1100000,  // B
    7'b0001000,  // A
    7'b0001100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef enum logic {
    ST_SHOW,
    ST_GAP
  } scan_state_e;

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational hex-plus-valid to active-low segment pattern; invalid blanks.
module seven_seg_encoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  input  logic       valid_i,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (valid_i) seg_c = HEX_SEG[hex_i];
  end

endmodule

// File: rtl/seven_seg_scan_display.sv
// N-digit time-multiplexed seven-segment driver with a shift history of hex entries.
// Define SEG_BLANK_GAP_EN to insert an all-off blanking gap between digits.
module seven_seg_scan_display
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned DWELL_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES   = 16
) (
  input  logic                  int_osc,
  input  logic                  reset,
  input  logic                  en,
  input  logic [3:0]            digit,
  input  logic                  clr,
  output seg_t                  seg,
  output logic [NUM_DIGITS-1:0] osc
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef SEG_BLANK_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
`endif
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0]      hv_q, hv_d;
  logic [NUM_DIGITS-1:0][3:0] hx_q, hx_d;
  scan_state_e                state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [IDX_W-1:0]           idx_next;
  seg_t                       seg_q, seg_d;
  logic [NUM_DIGITS-1:0]      osc_q, osc_d;
  seg_t                       enc_seg;

  // History shift register; clear takes priority over a push in the same cycle
  always_comb begin
    hv_d = hv_q;
    hx_d = hx_q;
    if (clr) begin
      hv_d = '0;
    end else if (en) begin
      hv_d = {hv_q[NUM_DIGITS-2:0], 1'b1};
      hx_d = {hx_q[NUM_DIGITS-2:0], digit};
    end
  end

  assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

  // Scan FSM: dwell on a digit, optionally blank for a gap, then advance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    case (state_q)
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
`ifdef SEG_BLANK_GAP_EN
          state_d = ST_GAP;
`else
          idx_d = idx_next;
`endif
        end
      end
`ifdef SEG_BLANK_GAP_EN
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_next;
          state_d = ST_SHOW;
        end
      end
`endif
      default: begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end
    endcase
  end

  seven_seg_encoder u_encoder (
    .hex_i   (hx_q[idx_q]),
    .valid_i (hv_q[idx_q]),
    .seg_c   (enc_seg)
  );

  // Select and segments are registered together so they always switch on the same edge
  always_comb begin
    seg_d = enc_seg;
    osc_d = NUM_DIGITS'(1) << idx_q;
`ifdef SEG_BLANK_GAP_EN
    if (state_q == ST_GAP) begin
      seg_d = SEG_BLANK;
      osc_d = '0;
    end
`endif
  end

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      hv_q    <= '0;
      hx_q    <= '0;
      state_q <= ST_SHOW;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      osc_q   <= NUM_DIGITS'(1);
    end else begin
      hv_q    <= hv_d;
      hx_q    <= hx_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      osc_q   <= osc_d;
    end
  end

  assign seg = seg_q;
  assign osc = osc_q;

endmodule

// File: tb/tb_seven_seg_scan_display.sv
// Self-checking bench for seven_seg_scan_display (4 digits, dwell 8, gap 2).
module tb_seven_seg_scan_display;

  localparam int ND = 4;
  localparam int DW = 8;
  localparam int GP = 2;
`ifdef SEG_BLANK_GAP_EN
  localparam int PER = DW + GP;
`else
  localparam int PER = DW;
`endif
  localparam int SCAN = ND * PER;
  localparam int NV   = 21;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0001100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001;
  localparam logic [6:0] SD = 7'b1000010;
  localparam logic [6:0] SE = 7'b0110000;
  localparam logic [6:0] SF = 7'b0111000;

  typedef struct packed {
    logic            en;
    logic            clr;
    logic [3:0]      dig;
    logic [3:0][6:0] exp;
  } vec_t;

  logic          int_osc;
  logic          reset;
  logic          en;
  logic [3:0]    digit;
  logic          clr;
  logic [6:0]    seg;
  logic [ND-1:0] osc;

  int   checks;
  int   failures;
  int   k;
  vec_t vecs [NV];

  seven_seg_scan_display #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DW),
    .GAP_CYCLES   (GP)
  ) dut (
    .int_osc (int_osc),
    .reset   (reset),
    .en      (en),
    .digit   (digit),
    .clr     (clr),
    .seg     (seg),
    .osc     (osc)
  );

  initial int_osc = 1'b0;
  always #5 int_osc = ~int_osc;

  // Clock edges since the last reset release
  always @(posedge int_osc or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  function automatic int exp_idx(input int kk);
    if (kk == 0) return 0;
    return ((kk - 1) / PER) % ND;
  endfunction

  function automatic logic [3:0] exp_osc(input int kk);
    logic [3:0] r;
    r = 4'b0001;
    if (kk == 0) return r;
    if (((kk - 1) % PER) >= DW) return 4'b0000;
    return r << exp_idx(kk);
  endfunction

  function automatic vec_t mk(input logic e, input logic c, input logic [3:0] d,
                              input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    vec_t v;
    v.en  = e;
    v.clr = c;
    v.dig = d;
    v.exp = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic check_scan(input logic [3:0][6:0] e, input int n, input int tag);
    logic [3:0] eo;
    logic [6:0] es;
    for (int c = 0; c < n; c++) begin
      @(negedge int_osc);
      eo = exp_osc(k);
      es = (eo == 4'b0000) ? BL : e[exp_idx(k)];
      checks++;
      if (osc !== eo) begin
        failures++;
        $display("FAIL osc vec=%0d k=%0d got=%b exp=%b", tag, k, osc, eo);
      end
      checks++;
      if (seg !== es) begin
        failures++;
        $display("FAIL seg vec=%0d k=%0d got=%b exp=%b", tag, k, seg, es);
      end
    end
  endtask

  initial begin
    logic found;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    en       = 1'b0;
    clr      = 1'b0;
    digit    = 4'h0;

    vecs[0]  = mk(1, 0, 4'h5, S5, BL, BL, BL);
    vecs[1]  = mk(1, 0, 4'hA, SA, S5, BL, BL);
    vecs[2]  = mk(0, 1, 4'h0, BL, BL, BL, BL);
    vecs[3]  = mk(1, 0, 4'h1, S1, BL, BL, BL);
    vecs[4]  = mk(1, 0, 4'h2, S2, S1, BL, BL);
    vecs[5]  = mk(1, 0, 4'h3, S3, S2, S1, BL);
    vecs[6]  = mk(1, 0, 4'h4, S4, S3, S2, S1);
    vecs[7]  = mk(1, 0, 4'h5, S5, S4, S3, S2);
    vecs[8]  = mk(0, 1, 4'h0, BL, BL, BL, BL);
    vecs[9]  = mk(1, 0, 4'h9, S9, BL, BL, BL);
    vecs[10] = mk(1, 0, 4'h8, S8, S9, BL, BL);
    vecs[11] = mk(1, 0, 4'h0, S0, S8, S9, BL);
    vecs[12] = mk(1, 1, 4'h7, BL, BL, BL, BL);
    vecs[13] = mk(1, 0, 4'hB, SB, BL, BL, BL);
    vecs[14] = mk(1, 0, 4'hC, SC, SB, BL, BL);
    vecs[15] = mk(1, 0, 4'hD, SD, SC, SB, BL);
    vecs[16] = mk(1, 0, 4'hE, SE, SD, SC, SB);
    vecs[17] = mk(1, 0, 4'hF, SF, SE, SD, SC);
    vecs[18] = mk(1, 0, 4'h6, S6, SF, SE, SD);
    vecs[19] = mk(1, 0, 4'h7, S7, S6, SF, SE);
    vecs[20] = mk(1, 0, 4'h3, S3, S7, S6, SF);

    // Reset state, then two full idle scans (osc wraps back to digit 0)
    #12;
    checks++;
    if (seg !== BL) begin
      failures++;
      $display("FAIL reset_seg got=%b exp=%b", seg, BL);
    end
    checks++;
    if (osc !== 4'b0001) begin
      failures++;
      $display("FAIL reset_osc got=%b exp=%b", osc, 4'b0001);
    end
    reset = 1'b1;
    check_scan({BL, BL, BL, BL}, 2 * SCAN + 1, -1);

    for (int i = 0; i < NV; i++) begin
      @(posedge int_osc);
      #1;
      en    = vecs[i].en;
      clr   = vecs[i].clr;
      digit = vecs[i].dig;
      @(posedge int_osc);
      #1;
      en    = 1'b0;
      clr   = 1'b0;
      @(posedge int_osc);
      check_scan(vecs[i].exp, SCAN, i);
    end

    // Asynchronous reset in the middle of the dwell on digit 2
    found = 1'b0;
    for (int c = 0; c < 4 * SCAN && !found; c++) begin
      @(negedge int_osc);
      if (osc === 4'b0100) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_digit2 got=timeout exp=osc_0100");
    end
    @(negedge int_osc);
    @(negedge int_osc);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (seg !== BL) begin
      failures++;
      $display("FAIL async_reset_seg got=%b exp=%b", seg, BL);
    end
    checks++;
    if (osc !== 4'b0001) begin
      failures++;
      $display("FAIL async_reset_osc got=%b exp=%b", osc, 4'b0001);
    end
    #1;
    reset = 1'b1;
    check_scan({BL, BL, BL, BL}, SCAN + 1, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_display.md
# seven_seg_scan_display

Parametrised, time-multiplexed driver for an N-digit common-segment seven-segment display. Holds a shift history of the last NUM_DIGITS hex entries (newest on digit 0), scans the digits with a programmable dwell, and blanks digits that have not yet received an entry. It sits between the keypad scanner/debouncer (which supplies `digit` + `en`) and the board's segment/select pins. It generalises the two-digit new/previous display to N digits, with configurable refresh and explicit clear.

## Interface
- `NUM_DIGITS`, 2: number of display digits and history depth; legal range ≥ 2.
- `DWELL_CYCLES`, 4096: `int_osc` cycles each digit is driven per scan; ≥ 2.
- `GAP_CYCLES`, 16: blanking cycles between digits; used only with `SEG_BLANK_GAP_EN`; ≥ 1.
- `int_osc`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  single-cycle strobe: push `digit` into history.
- `digit`  in  4  hex value pushed on `en`.
- `clr`  in  1  synchronous clear of history, active-high.
- `seg`  out  7  segment drive, active-low; bit 6 = a … bit 0 = g.
- `osc`  out  NUM_DIGITS  digit select, one-hot, active-high; bit i selects digit i.

## Operation
- History: NUM_DIGITS slots of {valid, 4-bit value}. On `en`: slot0 ← {1, `digit`}, slot i ← slot i-1; oldest slot is discarded.
- `clr` sets every valid bit to 0. When `clr` and `en` are asserted in the same cycle, `clr` wins and `en` is dropped.
- Encoding: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0001100, A→0001000, B→1100000, C→0110001, D→1000010, E→0110000, F→0111000.
- Invalid slot drives `seg` = 1111111 (blank), but its `osc` bit still asserts.
- Scan FSM states: SHOW and, with the macro, GAP.
  - SHOW: dwell counter counts 0 … DWELL_CYCLES-1.
  - At terminal count, digit index advances i → i+1, wrapping NUM_DIGITS-1 → 0.
  - With the macro, terminal count goes to GAP instead; GAP counts 0 … GAP_CYCLES-1, then advances the index and returns to SHOW.
- Dwell counter width: $clog2(max(DWELL_CYCLES, GAP_CYCLES)). Index width: $clog2(NUM_DIGITS). Counters wrap only at terminal count, never by overflow.
- `en` and `clr` are accepted in every FSM state; the scan never stalls.

## Timing
- Reset values:
  - History invalid, values 0.
  - Index 0, dwell counter 0, state SHOW.
  - `seg` = 1111111, `osc` = one-hot bit 0.
- `seg` and `osc` are registered and reflect index/state/history from the previous cycle. An index change appears on outputs 1 cycle after the terminal-count cycle.
- `en` at cycle t: history updated at t+1; `seg` shows the new value at t+2 if that slot is the one being scanned.
- `clr` at cycle t: currently scanned digit blanks at t+2.
- `osc` and `seg` change in the same cycle; no cycle drives a new select with the old segment pattern.
- `reset` asserted mid-scan clears everything immediately (asynchronous). The first full dwell on digit 0 starts on the first clock edge after release.

## Configuration
- `SEG_BLANK_GAP_EN` defined: GAP state compiled in. Between digits, `osc` = all-zero and `seg` = 1111111 for GAP_CYCLES (anti-ghosting). Scan period = NUM_DIGITS·(DWELL_CYCLES+GAP_CYCLES).
- `SEG_BLANK_GAP_EN` undefined: no GAP state, and `GAP_CYCLES` is ignored. Selects switch directly digit to digit. Scan period = NUM_DIGITS·DWELL_CYCLES.

## Structure
- Shared package `seven_seg_pkg` holds:
  - `seg_t` (logic [6:0]).
  - `SEG_BLANK` constant = 7'b1111111.
  - The hex-to-segment constant table.
  - The scan-state enum.
- One sub-module, `seven_seg_encoder`: combinational 4-bit hex plus valid in → `seg_t` out. It is instantiated once, on the scanned slot.
- History shift register, dwell counter and scan FSM live in the top module.

## Test plan
Bench configuration: NUM_DIGITS=4, DWELL_CYCLES=8, GAP_CYCLES=2.
- Reset release, no input → `seg`=1111111 in every dwell; `osc` sequence 0001, 0010, 0100, 1000, 0001 with 8 cycles each.
- `en` with `digit`=5, then `digit`=A → digit 0 shows 0001000 (A), digit 1 shows 0100100 (5), digits 2–3 stay blank.
- Push 1, 2, 3, 4, 5 → digits 0..3 show 5, 4, 3, 2; the value 1 is discarded.
- `clr` and `en` (`digit`=7) in the same cycle after three entries → all digits blank; 0001111 never appears.
- `reset` pulled low mid-dwell on digit 2 → outputs return to `seg`=1111111 and `osc`=0001 without a clock edge; history is empty afterwards.
- With `SEG_BLANK_GAP_EN`: after each 8-cycle dwell, `osc`=0000 and `seg`=1111111 for exactly 2 cycles. Without the macro: no all-zero `osc` cycle ever occurs.
